// File: rtl/light_sched_pkg.sv
// light_sched_pkg: shared types and helpers for the lighting power-budget scheduler.
//   zone_state_e    : per-zone FSM encoding
//   HOLD_CYCLES_DEF : default hold reload (1 s at 50 MHz)
//   popcount16      : population count of up to 16 zone bits
package light_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    ON   = 2'b10,
    HOLD = 2'b11
  } zone_state_e;

  localparam int HOLD_CYCLES_DEF = 50_000_000;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < 16; i++) c = c + {4'b0, v[i]};
    return c;
  endfunction

endpackage

// File: rtl/light_zone_fsm.sv
// light_zone_fsm: one lighting zone -- optional PIR synchronizer, IDLE/REQ/ON/HOLD
// FSM and hold-time down-counter.
//   clk, reset_n : clock, async active-low reset
//   enable       : low forces the zone to IDLE with a cleared counter
//   pir          : raw motion input
//   grant        : one-cycle grant from the top-level arbiter
//   req          : zone is in REQ with motion still present (eligible for grant)
//   light_on     : zone lit (ON or HOLD)
//   pending      : zone in REQ
// Build option: LIGHT_SCHED_SYNC_EN adds a 2-flop synchronizer on pir.
module light_zone_fsm
  import light_sched_pkg::*;
#(
  parameter int HOLD_CYCLES = HOLD_CYCLES_DEF,
  parameter int CW          = $clog2(HOLD_CYCLES + 1)
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  input  logic pir,
  input  logic grant,
  output logic req,
  output logic light_on,
  output logic pending
);

  localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYCLES);

  logic pir_early;  // earliest usable copy of pir, arms REQ
  logic pir_s;      // fully conditioned pir, qualifies every other transition

`ifdef LIGHT_SCHED_SYNC_EN
  logic [1:0] sync;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) sync <= '0;
    else          sync <= {sync[0], pir};
  // REQ is armed off the first stage so the REQ edge coincides with the second
  // synchronizer edge; grant and withdrawal still look at the second stage.
  assign pir_early = sync[0];
  assign pir_s     = sync[1];
`else
  assign pir_early = pir;
  assign pir_s     = pir;
`endif

  zone_state_e   state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (!enable) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE: if (pir_early) state_nxt = REQ;
        REQ: begin
          if (!pir_s) state_nxt = IDLE;  // motion ended before a slot came up
          else if (grant) begin
            state_nxt = ON;
            cnt_nxt   = HOLD_LD;
          end
        end
        ON: begin
          if (pir_s) cnt_nxt = HOLD_LD;
          else       state_nxt = HOLD;
        end
        HOLD: begin
          // retrigger keeps the slot; no trip through the arbiter
          if (pir_s) begin
            state_nxt = ON;
            cnt_nxt   = HOLD_LD;
          end else if (cnt == '0) state_nxt = IDLE;
          else                    cnt_nxt = cnt - 1'b1;
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_comb begin
    req      = (state == REQ) && pir_s;
    light_on = (state == ON) || (state == HOLD);
    pending  = (state == REQ);
  end

endmodule

// File: rtl/light_zone_scheduler.sv
// light_zone_scheduler: power-budget scheduler for PIR-driven lighting zones.
// Each zone holds its light for a hold time after motion ends; at most MAX_ON
// zones are lit at once and waiting zones are granted round-robin, one per cycle.
//   clk, reset_n : clock, async active-low reset
//   enable       : low forces all zones off (rr_ptr held)
//   pir          : raw motion inputs, one per zone
//   light_on     : light drive per zone
//   pending      : zone requesting but not yet granted
//   active_count : number of lit zones
// Build option: LIGHT_SCHED_SYNC_EN enables the per-zone pir synchronizers.
module light_zone_scheduler
  import light_sched_pkg::*;
#(
  parameter  int N_ZONES     = 4,
  parameter  int MAX_ON      = 2,
  parameter  int HOLD_CYCLES = HOLD_CYCLES_DEF,
  localparam int AW          = $clog2(MAX_ON + 1),
  localparam int PW          = $clog2(N_ZONES)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enable,
  input  logic [N_ZONES-1:0] pir,
  output logic [N_ZONES-1:0] light_on,
  output logic [N_ZONES-1:0] pending,
  output logic [AW-1:0]      active_count
);

  logic [N_ZONES-1:0] req;
  logic [N_ZONES-1:0] grant;
  logic [PW-1:0]      rr_ptr;
  logic [PW-1:0]      gnt_idx;
  logic               gnt_any;
  logic [4:0]         cnt_full;

  light_zone_fsm #(.HOLD_CYCLES(HOLD_CYCLES)) u_zone [N_ZONES-1:0] (
    .clk      (clk),
    .reset_n  (reset_n),
    .enable   (enable),
    .pir      (pir),
    .grant    (grant),
    .req      (req),
    .light_on (light_on),
    .pending  (pending)
  );

  // Count comes from the zone state registers, so a slot freed at an edge is
  // only seen as free in the cycle after it.
  assign cnt_full     = popcount16(16'(light_on));
  assign active_count = cnt_full[AW-1:0];

  always_comb begin
    int idx;
    idx     = 0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    grant   = '0;
    if (enable && (int'(cnt_full) < MAX_ON)) begin
      for (int k = 0; k < N_ZONES; k++) begin
        idx = int'(rr_ptr) + k;
        if (idx >= N_ZONES) idx = idx - N_ZONES;
        if (!gnt_any && req[idx]) begin
          gnt_any = 1'b1;
          gnt_idx = PW'(idx);
        end
      end
    end
    if (gnt_any) grant[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) rr_ptr <= '0;
    else if (gnt_any)
      rr_ptr <= (gnt_idx == PW'(N_ZONES - 1)) ? '0 : gnt_idx + 1'b1;

endmodule

// File: tb/tb_light_zone_scheduler.sv
// Directed bench for light_zone_scheduler: N_ZONES=4, MAX_ON=2, HOLD_CYCLES=10.
// Expected edge numbers are written in terms of SL (1 with the synchronizer built
// in, 0 without): REQ at edge 1+SL, ON at edge 2+SL, pir changes seen 2*SL edges late.
module tb_light_zone_scheduler;
  localparam int HC = 10;
`ifdef LIGHT_SCHED_SYNC_EN
  localparam int SL = 1;
`else
  localparam int SL = 0;
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  logic       enable;
  logic [3:0] pir;
  logic [3:0] light_on;
  logic [3:0] pending;
  logic [1:0] active_count;

  int checks   = 0;
  int failures = 0;

  light_zone_scheduler #(.N_ZONES(4), .MAX_ON(2), .HOLD_CYCLES(HC)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .pir          (pir),
    .light_on     (light_on),
    .pending      (pending),
    .active_count (active_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    enable  = 1'b1;
    pir     = '0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic wait_light(input int z, input logic val, input int max, input string tag);
    int n;
    n = 0;
    while (light_on[z] !== val && n < max) begin
      tick();
      n++;
    end
    chk(tag, 32'(light_on[z]), 32'(val));
  endtask

  // budget invariant, every cycle out of reset
  always @(negedge clk)
    if (reset_n === 1'b1) begin
      checks++;
      assert (active_count <= 2'd2) else begin
        failures++;
        $error("FAIL invariant observed=%0d expected<=2", active_count);
      end
    end

  initial begin
    #300000;
    $display("FAIL timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

  initial begin
    int drops, pend_seen, lit_seen;

    // ---- reset state
    reset_n = 1'b0;
    enable  = 1'b1;
    pir     = '0;
    #2;
    chk("rst_light", 32'(light_on), 32'h0);
    chk("rst_pending", 32'(pending), 32'h0);
    chk("rst_count", 32'(active_count), 32'h0);
    tick();
    tick();
    reset_n = 1'b1;

    // ---- single zone: pir[0] high for 5 sampling edges
    pir = 4'b0001;
    for (int k = 1; k <= 20 + 2 * SL; k++) begin
      tick();
      if (k == 5) pir = 4'b0000;
      chk($sformatf("single_light_k%0d", k), 32'(light_on[0]),
          32'((k >= 2 + SL) && (k < 17 + 2 * SL)));
      chk($sformatf("single_pend_k%0d", k), 32'(pending[0]), 32'(k == 1 + SL));
    end
    chk("single_count_end", 32'(active_count), 32'h0);

    // ---- budget: zones 0..2 request together
    do_reset();
    pir = 4'b0111;
    for (int k = 1; k <= 24 + 2 * SL; k++) begin
      tick();
      if (k == 10) pir[0] = 1'b0;
      if (k == 2 + SL) begin
        chk("bud_z0_on", 32'(light_on[0]), 32'h1);
        chk("bud_z1_wait", 32'(light_on[1]), 32'h0);
      end
      if (k == 3 + SL) begin
        chk("bud_z1_on", 32'(light_on[1]), 32'h1);
        chk("bud_z2_pend", 32'(pending[2]), 32'h1);
        chk("bud_full", 32'(active_count), 32'h2);
      end
      if (k == 21 + 2 * SL) begin
        chk("bud_z0_last", 32'(light_on[0]), 32'h1);
        chk("bud_z2_still", 32'(pending[2]), 32'h1);
      end
      if (k == 22 + 2 * SL) begin
        chk("bud_z0_off", 32'(light_on[0]), 32'h0);
        chk("bud_z2_notyet", 32'(light_on[2]), 32'h0);
        chk("bud_count1", 32'(active_count), 32'h1);
      end
      if (k == 23 + 2 * SL) begin
        chk("bud_z2_on", 32'(light_on[2]), 32'h1);
        chk("bud_z2_pend_clr", 32'(pending[2]), 32'h0);
        chk("bud_count2", 32'(active_count), 32'h2);
      end
    end

    // ---- round robin: zones 0,2 lit (last grant to 2), zones 1,3 waiting
    do_reset();
    pir = 4'b0101;
    wait_light(2, 1'b1, 10, "rr_z2_on");
    chk("rr_z0_on", 32'(light_on[0]), 32'h1);
    pir = 4'b1111;
    repeat (4) tick();
    chk("rr_waiting", 32'(pending), 32'hA);
    pir[0] = 1'b0;
    wait_light(0, 1'b0, 30, "rr_z0_off");
    chk("rr_z3_notyet", 32'(light_on[3]), 32'h0);
    tick();
    chk("rr_z3_first", 32'(light_on[3]), 32'h1);
    chk("rr_z1_waits", 32'(pending[1]), 32'h1);
    pir[2] = 1'b0;
    wait_light(2, 1'b0, 30, "rr_z2_off");
    tick();
    chk("rr_z1_second", 32'(light_on[1]), 32'h1);

    // ---- retrigger 4 cycles into HOLD
    do_reset();
    pir = 4'b0001;
    wait_light(0, 1'b1, 10, "rt_on");
    repeat (3) tick();
    pir = 4'b0000;
    drops = 0;
    pend_seen = 0;
    for (int k = 0; k < 1 + 2 * SL + 4; k++) begin
      tick();
      if (light_on[0] !== 1'b1) drops++;
      if (pending[0] !== 1'b0) pend_seen++;
    end
    pir = 4'b0001;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (light_on[0] !== 1'b1) drops++;
      if (pending[0] !== 1'b0) pend_seen++;
    end
    chk("rt_no_drop", 32'(drops), 32'h0);
    chk("rt_no_rearb", 32'(pend_seen), 32'h0);
    chk("rt_count", 32'(active_count), 32'h1);

    // ---- withdrawn request while budget is full
    do_reset();
    pir = 4'b0011;
    wait_light(1, 1'b1, 10, "wd_z1_on");
    pir[2] = 1'b1;
    pend_seen = 0;
    lit_seen = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (k == 2) pir[2] = 1'b0;
      if (pending[2] === 1'b1) pend_seen++;
      if (light_on[2] !== 1'b0) lit_seen++;
    end
    chk("wd_pend_rose", 32'(pend_seen != 0), 32'h1);
    chk("wd_pend_clr", 32'(pending[2]), 32'h0);
    chk("wd_never_lit", 32'(lit_seen), 32'h0);

    // ---- enable low for one cycle with two zones lit
    enable = 1'b0;
    tick();
    enable = 1'b1;
    chk("en_light", 32'(light_on), 32'h0);
    chk("en_pending", 32'(pending), 32'h0);
    chk("en_count", 32'(active_count), 32'h0);
    wait_light(1, 1'b1, 10, "en_relight");
    chk("en_relight_cnt", 32'(active_count), 32'h2);

    // ---- async reset in the middle of HOLD
    pir = 4'b0000;
    repeat (1 + 2 * SL + 3) tick();
    chk("rst_pre_hold", 32'(light_on[0]), 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_async_light", 32'(light_on), 32'h0);
    chk("rst_async_pend", 32'(pending), 32'h0);
    chk("rst_async_cnt", 32'(active_count), 32'h0);
    tick();
    reset_n = 1'b1;
    tick();
    chk("rst_stays_off", 32'(light_on), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
